// File: rtl/vid_pkg.sv
// Shared types and constants for the video stream monitor and pattern generator.
package vid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    NEXT_SOF
  } vid_mon_state_t;

  localparam int unsigned SCRN_WIDTH  = 1280;
  localparam int unsigned SCRN_HEIGHT = 720;

  // Colour constants shared with the pattern generator.
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] RED = 24'hFF0000;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to create pseudo-random backpressure.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr = lfsr_q;

  // Advance every clock; seeded on reset so the sequence is repeatable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

endmodule

// File: rtl/vid_stream_monitor.sv
// AXI4-Stream video sink: measures line/frame geometry, counts frames, flags protocol errors
// and reports lock. Define VID_MON_BACKPRESSURE_EN to add LFSR-driven pseudo-random tready.
module vid_stream_monitor
  import vid_pkg::*;
#(
  parameter int unsigned DATAW      = 32,
  parameter int unsigned EXP_WIDTH  = SCRN_WIDTH,
  parameter int unsigned EXP_HEIGHT = SCRN_HEIGHT,
  parameter int unsigned CNTW       = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr_status,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic [CNTW-1:0]  last_line_len,
  output logic [CNTW-1:0]  last_frame_lines,
  output logic [DATAW-1:0] sof_pixel,
  output logic             err_short_line,
  output logic             err_long_line,
  output logic             err_early_sof,
  output logic             err_missing_sof,
  output logic             locked
);

  localparam logic [CNTW-1:0] PixLast  = CNTW'(EXP_WIDTH - 1);
  localparam logic [CNTW-1:0] LineLast = CNTW'(EXP_HEIGHT - 1);
  localparam logic [CNTW-1:0] CntOne   = CNTW'(1);
  localparam logic [CNTW-1:0] CntMax   = {CNTW{1'b1}};

  vid_mon_state_t   state_q, state_d;
  logic             tready_q, tready_d;
  logic [CNTW-1:0]  pix_q, pix_d, line_q, line_d;
  logic [CNTW-1:0]  pix_eff, line_eff, pix_inc;
  logic [CNTW-1:0]  len_q, len_d, lines_q, lines_d;
  logic [DATAW-1:0] sof_q, sof_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             done_q, done_d;
  logic             e_short_q, e_short_d, e_long_q, e_long_d;
  logic             e_early_q, e_early_d, e_miss_q, e_miss_d;
  logic             ev_short, ev_long, ev_early, ev_miss;
  logic             frame_ok_q, frame_ok_d;
  logic [1:0]       good_q, good_d;
  logic             locked_q, locked_d;
  logic             accept, sof, run, complete;

`ifdef VID_MON_BACKPRESSURE_EN
  logic [15:0] lfsr_val;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .lfsr (lfsr_val)
  );

  assign tready_d = en && (lfsr_val[1:0] != 2'b00);
`else
  assign tready_d = en;
`endif

  assign accept = s_axis_tvalid && tready_q;

  // Next-state: FSM, counters, measurements, error events and lock tracking.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    line_d     = line_q;
    len_d      = len_q;
    lines_d    = lines_q;
    sof_d      = sof_q;
    fcnt_d     = clr_status ? 16'd0 : fcnt_q;
    done_d     = 1'b0;
    frame_ok_d = frame_ok_q;
    good_d     = good_q;
    locked_d   = locked_q;
    ev_short   = 1'b0;
    ev_long    = 1'b0;
    ev_early   = 1'b0;
    ev_miss    = 1'b0;
    sof        = 1'b0;
    run        = 1'b0;
    complete   = 1'b0;
    pix_eff    = '0;
    line_eff   = '0;
    pix_inc    = '0;

    if (!en) begin
      state_d  = IDLE;
      pix_d    = '0;
      line_d   = '0;
      good_d   = 2'd0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_SOF;
        WAIT_SOF: begin
          if (accept && s_axis_tuser) begin
            sof = 1'b1;
            run = 1'b1;
          end
        end
        NEXT_SOF: begin
          if (accept) begin
            if (s_axis_tuser) begin
              sof = 1'b1;
              run = 1'b1;
            end else begin
              ev_miss = 1'b1;
              state_d = WAIT_SOF;
            end
          end
        end
        ACTIVE: begin
          if (accept) begin
            run = 1'b1;
            if (s_axis_tuser) begin
              sof = 1'b1;
              if ((pix_q != '0) || (line_q != '0)) begin
                ev_early = 1'b1;
                lines_d  = line_q;
              end
            end else begin
              pix_eff  = pix_q;
              line_eff = line_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // SOF restarts at pixel 0 / line 0 (pix_eff/line_eff already zero), then the beat
      // is processed like any other, so tuser+tlast on one beat is a 1-beat line.
      if (sof) begin
        sof_d      = s_axis_tdata;
        frame_ok_d = 1'b1;
        state_d    = ACTIVE;
      end

      if (run) begin
        pix_inc = (pix_eff == CntMax) ? pix_eff : pix_eff + CntOne;
        if (s_axis_tlast) begin
          len_d = pix_inc;
          pix_d = '0;
          if (32'(pix_inc) < EXP_WIDTH) ev_short = 1'b1;
          if (line_eff == LineLast) begin
            complete = 1'b1;
            line_d   = '0;
            lines_d  = CNTW'(EXP_HEIGHT);
            state_d  = NEXT_SOF;
          end else begin
            line_d = line_eff + CntOne;
          end
        end else begin
          pix_d  = pix_inc;
          line_d = line_eff;
          if (pix_eff == PixLast) ev_long = 1'b1;
        end
      end

      if (ev_short || ev_long) frame_ok_d = 1'b0;
      if (ev_short || ev_long || ev_early || ev_miss) begin
        good_d   = 2'd0;
        locked_d = 1'b0;
      end

      if (complete) begin
        fcnt_d = fcnt_d + 16'd1;
        done_d = 1'b1;
        if (frame_ok_d) begin
          good_d = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
          if (good_d == 2'd2) locked_d = 1'b1;
        end
      end
    end

    // A new error event in the same cycle as clr_status wins.
    e_short_d = ev_short | (e_short_q & ~clr_status);
    e_long_d  = ev_long  | (e_long_q  & ~clr_status);
    e_early_d = ev_early | (e_early_q & ~clr_status);
    e_miss_d  = ev_miss  | (e_miss_q  & ~clr_status);
  end

  // State and status registers; everything clears on asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      len_q      <= '0;
      lines_q    <= '0;
      sof_q      <= '0;
      fcnt_q     <= 16'd0;
      done_q     <= 1'b0;
      e_short_q  <= 1'b0;
      e_long_q   <= 1'b0;
      e_early_q  <= 1'b0;
      e_miss_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      good_q     <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      len_q      <= len_d;
      lines_q    <= lines_d;
      sof_q      <= sof_d;
      fcnt_q     <= fcnt_d;
      done_q     <= done_d;
      e_short_q  <= e_short_d;
      e_long_q   <= e_long_d;
      e_early_q  <= e_early_d;
      e_miss_q   <= e_miss_d;
      frame_ok_q <= frame_ok_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
    end
  end

  assign s_axis_tready    = tready_q;
  assign frame_cnt        = fcnt_q;
  assign frame_done       = done_q;
  assign last_line_len    = len_q;
  assign last_frame_lines = lines_q;
  assign sof_pixel        = sof_q;
  assign err_short_line   = e_short_q;
  assign err_long_line    = e_long_q;
  assign err_early_sof    = e_early_q;
  assign err_missing_sof  = e_miss_q;
  assign locked           = locked_q;

endmodule
